// File: rtl/signal_change_logger.sv
// signal_change_logger: per-channel level-change monitor with timestamped event FIFO (FWFT, valid/ready).
// Optional SCL_DEBOUNCE_EN adds a per-channel stability window. Rev 1.0
`default_nettype none

module signal_change_logger #(
  parameter int NUM_CH          = 3,
  parameter int TS_WIDTH        = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   sig_in,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [CH_W-1:0]     ev_chan,
  output logic                ev_level,
  output logic [TS_WIDTH-1:0] ev_time,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [7:0]          drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EV_W  = CH_W + 1 + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts;
  logic [NUM_CH-1:0]   last;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   pend_level;
  logic [TS_WIDTH-1:0] pend_time [NUM_CH];
  logic [NUM_CH-1:0]   change;

  logic [EV_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [LVL_W-1:0]    count;

  logic                pop;
  logic                push;
  logic                any_pend;
  logic [CH_W-1:0]     sel;
  logic                sel_level;
  logic [TS_WIDTH-1:0] sel_time;
  logic [4:0]          drop_inc;
  logic [8:0]          drop_sum;
  logic [7:0]          drop_next;
  logic [EV_W-1:0]     head;

`ifdef SCL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] db_cnt [NUM_CH];

  // A channel only counts as changed on the last cycle of an unbroken differing run.
  always_comb begin
    change = '0;
    for (int c = 0; c < NUM_CH; c++)
      change[c] = (sig_in[c] != last[c]) && (db_cnt[c] == DB_W'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst || (sig_in[c] == last[c]) || change[c])
        db_cnt[c] <= '0;
      else
        db_cnt[c] <= db_cnt[c] + 1'b1;
    end
  end
`else
  always_comb change = sig_in ^ last;
`endif

  // Lowest-index pending channel wins the single push slot.
  always_comb begin
    any_pend  = 1'b0;
    sel       = '0;
    sel_level = 1'b0;
    sel_time  = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        any_pend  = 1'b1;
        sel       = CH_W'(c);
        sel_level = pend_level[c];
        sel_time  = pend_time[c];
      end
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign push = any_pend && ((count != LVL_W'(FIFO_DEPTH)) || pop);

  // A change on a still-pending channel that is not leaving this cycle overwrites it.
  always_comb begin
    drop_inc = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (change[c] && pending[c] && !(push && (sel == CH_W'(c))))
        drop_inc = drop_inc + 5'd1;
    drop_sum  = {1'b0, drop_cnt} + {4'b0000, drop_inc};
    drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      last       <= sig_in;
      pending    <= '0;
      pend_level <= '0;
      for (int c = 0; c < NUM_CH; c++) pend_time[c] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (change[c]) begin
          last[c]       <= sig_in[c];
          pending[c]    <= 1'b1;
          pend_level[c] <= sig_in[c];
          pend_time[c]  <= ts;
        end else if (push && (sel == CH_W'(c))) begin
          pending[c] <= 1'b0;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      drop_cnt <= drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {sel, sel_level, sel_time};
  end

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_chan    = ev_valid ? head[EV_W-1 -: CH_W] : '0;
  assign ev_level   = ev_valid ? head[TS_WIDTH] : 1'b0;
  assign ev_time    = ev_valid ? head[TS_WIDTH-1:0] : '0;
  assign fifo_level = count;

endmodule

`default_nettype wire

// File: tb/tb_signal_change_logger.sv
// Randomized + directed bench for signal_change_logger against a queue-based event model.
`default_nettype none

module tb_signal_change_logger;

  localparam int NCH   = 3;
`ifdef SCL_DEBOUNCE_EN
  localparam int TSW   = 6;
`else
  localparam int TSW   = 4;
`endif
  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sig_in = '0;
  logic           ev_ready = 1'b0;
  logic           ev_valid;
  logic [1:0]     ev_chan;
  logic           ev_level;
  logic [TSW-1:0] ev_time;
  logic [3:0]     fifo_level;
  logic [7:0]     drop_cnt;

  int checks = 0;
  int failures = 0;

  signal_change_logger #(
    .NUM_CH(NCH), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_level(ev_level), .ev_time(ev_time),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int chan; int level; int tstamp; } ev_t;
  ev_t q[$];
  int  m_ts;
  int  m_drop;
  bit  m_last [NCH];
  bit  m_pend [NCH];
  int  m_plev [NCH];
  int  m_ptime[NCH];
  int  m_run  [NCH];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behaviour of one clock edge, from the pre-edge state and the sampled inputs.
  task automatic model_edge();
    int  pre;
    bit  popping;
    int  pc;
    bit  pushing;
    bit  chg;
    ev_t e;
    if (rst) begin
      m_ts = 0; m_drop = 0; q.delete();
      for (int c = 0; c < NCH; c++) begin
        m_last[c] = sig_in[c]; m_pend[c] = 0; m_run[c] = 0;
      end
    end else begin
      pre     = q.size();
      popping = (pre > 0) && ev_ready;
      pc      = -1;
      for (int c = 0; c < NCH; c++) if (m_pend[c] && pc < 0) pc = c;
      pushing = (pc >= 0) && ((pre < DEPTH) || popping);
      e = '{chan: 0, level: 0, tstamp: 0};
      if (pushing) begin
        e = '{chan: pc, level: m_plev[pc], tstamp: m_ptime[pc]};
        m_pend[pc] = 0;
      end
      if (popping) void'(q.pop_front());
      if (pushing) q.push_back(e);
      for (int c = 0; c < NCH; c++) begin
`ifdef SCL_DEBOUNCE_EN
        if (sig_in[c] != m_last[c]) m_run[c]++; else m_run[c] = 0;
        chg = (m_run[c] >= DEB);
        if (chg) m_run[c] = 0;
`else
        chg = (sig_in[c] != m_last[c]);
`endif
        if (chg) begin
          if (m_pend[c]) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
          m_pend[c]  = 1;
          m_plev[c]  = int'(sig_in[c]);
          m_ptime[c] = m_ts;
          m_last[c]  = sig_in[c];
        end
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (q.size() > 0);
    check_eq("ev_valid", int'(ev_valid), int'(v));
    check_eq("fifo_level", int'(fifo_level), q.size());
    check_eq("drop_cnt", int'(drop_cnt), m_drop);
    check_eq("ev_chan", int'(ev_chan), v ? q[0].chan : 0);
    check_eq("ev_level", int'(ev_level), v ? q[0].level : 0);
    check_eq("ev_time", int'(ev_time), v ? q[0].tstamp : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic [NCH-1:0] s);
    rst = 1'b1; sig_in = s;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic advance_to(input int t);
    int n;
    n = 0;
    while (m_ts != t && n < 200) begin step(); n++; end
    check_eq("advance_bound", int'(m_ts == t), 1);
  endtask

  int pops;
  int last_lev;

  initial begin
    // Reset never generates events even with nonzero inputs.
    do_reset(3'b101);
    repeat (20) step();
    check_eq("s1_valid", int'(ev_valid), 0);
    check_eq("s1_drop", int'(drop_cnt), 0);

`ifndef SCL_DEBOUNCE_EN
    // Single change, one cycle of latency.
    do_reset(3'b000);
    ev_ready = 1'b1;
    advance_to(5);
    sig_in[1] = 1'b1;
    step();
    check_eq("s2_pre_valid", int'(ev_valid), 0);
    ev_ready = 1'b0;
    step();
    check_eq("s2_chan", int'(ev_chan), 1);
    check_eq("s2_level", int'(ev_level), 1);
    check_eq("s2_time", int'(ev_time), 5);

    // Simultaneous changes queue in channel order.
    do_reset(3'b000);
    ev_ready = 1'b0;
    advance_to(10);
    sig_in = 3'b111;
    repeat (4) step();
    check_eq("s3_level", int'(fifo_level), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("s3_chan", int'(ev_chan), i);
      check_eq("s3_time", int'(ev_time), 10);
      ev_ready = 1'b1; step(); ev_ready = 1'b0;
    end

    // Overflow: full FIFO, one pending, three drops.
    do_reset(3'b000);
    ev_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin sig_in[0] = ~sig_in[0]; step(); end
    check_eq("s4_level", int'(fifo_level), 8);
    check_eq("s4_drop", int'(drop_cnt), 3);
    ev_ready = 1'b1;
    pops = 0; last_lev = -1;
    for (int i = 0; i < 15; i++) begin
      if (ev_valid) begin pops++; last_lev = int'(ev_level); end
      step();
    end
    check_eq("s4_pops", pops, 9);
    check_eq("s4_last_level", last_lev, int'(sig_in[0]));

    // Timestamp wrap.
    do_reset(3'b000);
    ev_ready = 1'b0;
    advance_to(15);
    sig_in[2] = 1'b1; step();
    sig_in[2] = 1'b0; step();
    step();
    check_eq("s5_time15", int'(ev_time), 15);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    check_eq("s5_time0", int'(ev_time), 0);
`else
    // Short pulse is filtered; a full window is reported at its final cycle.
    do_reset(3'b000);
    ev_ready = 1'b0;
    sig_in[0] = 1'b1; repeat (3) step();
    sig_in[0] = 1'b0; repeat (10) step();
    check_eq("s6_pulse", int'(ev_valid), 0);
    advance_to(20);
    sig_in[0] = 1'b1;
    repeat (5) step();
    check_eq("s6_valid", int'(ev_valid), 1);
    check_eq("s6_time", int'(ev_time), 23);
`endif

    // Randomized traffic with occasional mid-run resets.
    do_reset(NCH'($urandom));
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      ev_ready = ($urandom_range(0, 3) != 0) ^ (i[9] & i[8]);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 4) == 0) sig_in[c] = ~sig_in[c];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
